// File: rtl/am_err_pkg.sv
// Shared FSM type and accumulator width helpers for the approximate-multiplier
// error-statistics accumulator.
package am_err_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    function automatic int unsigned sse_width(input int unsigned w, input int unsigned log2n);
        return 4 * w + log2n;
    endfunction

    function automatic int unsigned sae_width(input int unsigned w, input int unsigned log2n);
        return 2 * w + log2n;
    endfunction

    function automatic int unsigned bias_width(input int unsigned w, input int unsigned log2n);
        return 2 * w + 1 + log2n;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned log2n);
        return log2n + 1;
    endfunction

endpackage

// File: rtl/am_err_accum_if.sv
// Sample stream, control and result bundle of am_err_accum; the sample source
// and result consumer use the master side.
interface am_err_accum_if
    import am_err_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned LOG2N = 16
) ();

    logic                               start;
    logic                               in_valid;
    logic                               in_ready;
    logic [W-1:0]                       x;
    logic [W-1:0]                       y;
    logic [2*W-1:0]                     z_apx;
    logic                               busy;
    logic                               res_valid;
    logic [sse_width(W, LOG2N)-1:0]     sse;
    logic [sae_width(W, LOG2N)-1:0]     sae;
    logic [bias_width(W, LOG2N)-1:0]    bias;
    logic [2*W-1:0]                     max_ae;
    logic [cnt_width(LOG2N)-1:0]        nz_cnt;

    modport master (
        output start, in_valid, x, y, z_apx,
        input  in_ready, busy, res_valid, sse, sae, bias, max_ae, nz_cnt
    );

    modport slave (
        input  start, in_valid, x, y, z_apx,
        output in_ready, busy, res_valid, sse, sae, bias, max_ae, nz_cnt
    );

endinterface

// File: rtl/am_err_stage.sv
// Pipeline stages S1-S2: register exact/approximate products, then the signed
// error, its magnitude and its square.
module am_err_stage #(
    parameter int unsigned W = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    input  logic [W-1:0]        i_x,
    input  logic [W-1:0]        i_y,
    input  logic [2*W-1:0]      i_z_apx,
    output logic                o_s1_valid,
    output logic                o_valid,
    output logic signed [2*W:0] o_e,
    output logic [2*W-1:0]      o_abs_e,
    output logic [4*W-1:0]      o_sq_e
);

    logic                r_s1_valid;
    logic [2*W-1:0]      r_s1_exact;
    logic [2*W-1:0]      r_s1_apx;
    logic                r_s2_valid;
    logic signed [2*W:0] r_s2_e;
    logic [2*W-1:0]      r_s2_abs;
    logic [4*W-1:0]      r_s2_sq;

    logic [2*W-1:0]      w_prod;
    logic signed [2*W:0] w_e;
    logic signed [2*W:0] w_neg;
    logic [2*W-1:0]      w_abs;
    logic [4*W-1:0]      w_abs_ext;

    assign w_prod    = {{W{1'b0}}, i_x} * {{W{1'b0}}, i_y};
    assign w_e       = $signed({1'b0, r_s1_apx}) - $signed({1'b0, r_s1_exact});
    assign w_neg     = -w_e;
    // |e| <= 2^(2W)-1, so the top bit of the magnitude is always zero
    assign w_abs     = w_e[2*W] ? w_neg[2*W-1:0] : w_e[2*W-1:0];
    assign w_abs_ext = {{(2*W){1'b0}}, w_abs};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            r_s1_valid <= i_valid;
            r_s2_valid <= r_s1_valid;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_valid) begin
            r_s1_exact <= w_prod;
            r_s1_apx   <= i_z_apx;
        end
        if (r_s1_valid) begin
            r_s2_e   <= w_e;
            r_s2_abs <= w_abs;
            r_s2_sq  <= w_abs_ext * w_abs_ext;
        end
    end

    assign o_s1_valid = r_s1_valid;
    assign o_valid    = r_s2_valid;
    assign o_e        = r_s2_e;
    assign o_abs_e    = r_s2_abs;
    assign o_sq_e     = r_s2_sq;

endmodule

// File: rtl/am_err_accum.sv
// Windowed error-statistics accumulator for an 8x8 approximate multiplier:
// FSM, accept counter and the S3 accumulators.
module am_err_accum
    import am_err_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned LOG2N = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    am_err_accum_if.slave io_bus
);

    localparam int unsigned SseW  = sse_width(W, LOG2N);
    localparam int unsigned SaeW  = sae_width(W, LOG2N);
    localparam int unsigned BiasW = bias_width(W, LOG2N);
    localparam int unsigned CntW  = cnt_width(LOG2N);
    localparam logic [CntW-1:0] LastIdx = {1'b0, {LOG2N{1'b1}}};

    state_e              r_state;
    state_e              w_state_nxt;
    logic [CntW-1:0]     r_cnt;
    logic [SseW-1:0]     r_sse;
    logic [SaeW-1:0]     r_sae;
    logic [BiasW-1:0]    r_bias;
    logic [2*W-1:0]      r_max;
    logic [CntW-1:0]     r_nz;

    logic                w_accept;
    logic                w_last;
    logic                w_clear;
    logic                w_s1_valid;
    logic                w_s2_valid;
    logic signed [2*W:0] w_e;
    logic [2*W-1:0]      w_abs;
    logic [4*W-1:0]      w_sq;

    assign w_accept = io_bus.in_valid && (r_state == StRun);
    assign w_last   = w_accept && (r_cnt == LastIdx);

    am_err_stage #(
        .W (W)
    ) u_stage (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (w_accept),
        .i_x        (io_bus.x),
        .i_y        (io_bus.y),
        .i_z_apx    (io_bus.z_apx),
        .o_s1_valid (w_s1_valid),
        .o_valid    (w_s2_valid),
        .o_e        (w_e),
        .o_abs_e    (w_abs),
        .o_sq_e     (w_sq)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        unique case (r_state)
            StIdle, StDone: begin
                if (io_bus.start) begin
                    w_state_nxt = StRun;
                    w_clear     = 1'b1;
                end
            end
            StRun: begin
                if (w_last) w_state_nxt = StDrain;
            end
            // Once S1 is empty the last sample retires from S2 on this same edge
            StDrain: begin
                if (!w_s1_valid) w_state_nxt = StDone;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_sse   <= '0;
            r_sae   <= '0;
            r_bias  <= '0;
            r_max   <= '0;
            r_nz    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_clear) begin
                r_cnt  <= '0;
                r_sse  <= '0;
                r_sae  <= '0;
                r_bias <= '0;
                r_max  <= '0;
                r_nz   <= '0;
            end else begin
                if (w_accept) r_cnt <= r_cnt + CntW'(1);
                if (w_s2_valid) begin
                    r_sse  <= r_sse + SseW'(w_sq);
                    r_sae  <= r_sae + SaeW'(w_abs);
                    r_bias <= r_bias + BiasW'(w_e);
                    if (w_abs > r_max) r_max <= w_abs;
                    if (w_e != '0) r_nz <= r_nz + CntW'(1);
                end
            end
        end
    end

    assign io_bus.in_ready  = (r_state == StRun);
    assign io_bus.busy      = (r_state == StRun) || (r_state == StDrain);
    assign io_bus.res_valid = (r_state == StDone);
    assign io_bus.sse       = r_sse;
    assign io_bus.sae       = r_sae;
    assign io_bus.bias      = r_bias;
    assign io_bus.max_ae    = r_max;
    assign io_bus.nz_cnt    = r_nz;

endmodule

// File: tb/tb_am_err_accum.sv
// Scoreboard bench for am_err_accum: window results are modelled as samples are
// driven, queued, and compared when res_valid is seen.
module tb_am_err_accum;

    localparam int unsigned W     = 8;
    localparam int unsigned LOG2N = 4;
    localparam int          NWin  = 1 << LOG2N;

    typedef struct {
        longint sse;
        longint sae;
        longint bias;
        longint max_ae;
        longint nz;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int   n_cmp = 0;
    int   n_err = 0;
    res_t exp_q[$];

    longint m_sse, m_sae, m_bias, m_max, m_nz;
    int     n_acc;

    am_err_accum_if #(.W(W), .LOG2N(LOG2N)) bus ();

    am_err_accum #(
        .W     (W),
        .LOG2N (LOG2N)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rv"},   longint'(bus.res_valid), 0);
        check({tag, "_sse"},  longint'(bus.sse), 0);
        check({tag, "_sae"},  longint'(bus.sae), 0);
        check({tag, "_bias"}, longint'($signed(bus.bias)), 0);
        check({tag, "_max"},  longint'(bus.max_ae), 0);
        check({tag, "_nz"},   longint'(bus.nz_cnt), 0);
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        m_sse = 0; m_sae = 0; m_bias = 0; m_max = 0; m_nz = 0;
        n_acc = 0;
    endtask

    task automatic send(input int x, input int y, input int z);
        longint e, a;
        res_t   r;
        check("in_ready_when_sending", longint'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.x        = W'(x);
        bus.y        = W'(y);
        bus.z_apx    = (2*W)'(z);
        step();
        bus.in_valid = 1'b0;
        e = longint'(z) - longint'(x) * longint'(y);
        a = (e < 0) ? -e : e;
        m_sse += a * a;
        m_sae += a;
        m_bias += e;
        if (a > m_max) m_max = a;
        if (e != 0) m_nz++;
        n_acc++;
        if (n_acc == NWin) begin
            r.sse = m_sse; r.sae = m_sae; r.bias = m_bias; r.max_ae = m_max; r.nz = m_nz;
            exp_q.push_back(r);
        end
    endtask

    function automatic int err_z(input int x, input int y);
        int z;
        if ($urandom_range(0, 3) == 0) return x * y;
        z = x * y + int'($urandom_range(0, 600)) - 300;
        if (z < 0) z = 0;
        if (z > 65535) z = 65535;
        return z;
    endfunction

    task automatic send_rand();
        int x, y;
        x = int'($urandom_range(0, 255));
        y = int'($urandom_range(0, 255));
        send(x, y, err_z(x, y));
    endtask

    task automatic wait_result(input string tag);
        int   k;
        res_t r;
        k = 0;
        while (!bus.res_valid && k < 20) begin
            step();
            k++;
        end
        check({tag, "_res_valid_seen"}, longint'(bus.res_valid), 1);
        check({tag, "_queue_nonempty"}, longint'(exp_q.size() > 0), 1);
        if (bus.res_valid && exp_q.size() > 0) begin
            r = exp_q.pop_front();
            check({tag, "_sse"},  longint'(bus.sse), r.sse);
            check({tag, "_sae"},  longint'(bus.sae), r.sae);
            check({tag, "_bias"}, longint'($signed(bus.bias)), r.bias);
            check({tag, "_max"},  longint'(bus.max_ae), r.max_ae);
            check({tag, "_nz"},   longint'(bus.nz_cnt), r.nz);
            check({tag, "_busy_done"}, longint'(bus.busy), 0);
        end
    endtask

    initial begin
        int x, y;
        bus.start = 1'b0; bus.in_valid = 1'b0;
        bus.x = '0; bus.y = '0; bus.z_apx = '0;

        // Reset, with a simultaneous start that must lose
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        rst = 1'b0;
        check("rst_in_ready", longint'(bus.in_ready), 0);
        check("rst_busy", longint'(bus.busy), 0);
        check_zero("rst");

        // in_valid in IDLE is dropped
        bus.in_valid = 1'b1; bus.x = 8'd255; bus.y = 8'd255; bus.z_apx = '0;
        repeat (4) step();
        bus.in_valid = 1'b0;
        check("idle_busy", longint'(bus.busy), 0);
        check("idle_sae", longint'(bus.sae), 0);

        // Exact products over an unbroken window
        do_start();
        check("start_in_ready", longint'(bus.in_ready), 1);
        check("start_busy", longint'(bus.busy), 1);
        for (int i = 0; i < NWin; i++) begin
            x = int'($urandom_range(0, 255));
            y = int'($urandom_range(0, 255));
            send(x, y, x * y);
        end
        check("exact_ready_after_last", longint'(bus.in_ready), 0);
        check("exact_rv_plus1", longint'(bus.res_valid), 0);
        step();
        check("exact_rv_plus2", longint'(bus.res_valid), 0);
        step();
        check("exact_rv_plus3", longint'(bus.res_valid), 1);
        wait_result("exact");

        // Extreme error on every sample of a full window
        do_start();
        for (int i = 0; i < NWin; i++) send(255, 255, 0);
        wait_result("extreme");

        // Restart from DONE clears non-zero results; single-error window
        do_start();
        check_zero("restart");
        send(3, 255, 448);
        check("lat_sae_1", longint'(bus.sae), 0);
        step();
        check("lat_sae_2", longint'(bus.sae), 0);
        step();
        check("lat_sae_3", longint'(bus.sae), 317);
        send(2, 2, 4);
        for (int i = 2; i < NWin; i++) begin
            x = int'($urandom_range(0, 255));
            y = int'($urandom_range(0, 255));
            send(x, y, x * y);
        end
        wait_result("single");

        // Bubbles with a start pulse mid-RUN, then in_valid during DRAIN
        do_start();
        for (int i = 0; i < NWin; i++) begin
            send_rand();
            if (i != NWin - 1) begin
                if (i == 5) bus.start = 1'b1;
                step();
                bus.start = 1'b0;
            end
        end
        check("bubble_ready_after_last", longint'(bus.in_ready), 0);
        check("bubble_busy_drain", longint'(bus.busy), 1);
        bus.in_valid = 1'b1; bus.x = 8'd200; bus.y = 8'd100; bus.z_apx = 16'd7;
        step();
        bus.in_valid = 1'b0;
        wait_result("bubble");

        // Reset after 5 accepts discards the partial window
        do_start();
        for (int i = 0; i < 5; i++) send(255, 255, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_in_ready", longint'(bus.in_ready), 0);
        check("midrst_busy", longint'(bus.busy), 0);
        check_zero("midrst");
        step();
        step();
        check("midrst_flush_sae", longint'(bus.sae), 0);
        check("midrst_flush_nz", longint'(bus.nz_cnt), 0);
        do_start();
        for (int i = 0; i < NWin; i++) send_rand();
        wait_result("post_rst");

        check("queue_drained", longint'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
